div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit_step.sv | 22 ++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, start/ready levels
// and the width of the packed {HI, LO} result bus.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam int DOUBLE_REG_BUS = 64;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift one dividend bit into the partial
// remainder, trial-subtract the divisor and restore when it does not fit.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    assign trial = {rem, shift_in};

    // A set top bit means the trial value exceeds any WIDTH-bit divisor; the
    // kept difference is always below the divisor, so WIDTH bits hold it.
    assign q_bit    = trial[WIDTH] | (trial[WIDTH-1:0] >= divisor);
    assign rem_next = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Result is {remainder, quotient};
// handshake: start_i held high requests a division, ready_o (registered)
// stays high with a stable result until start_i is dropped.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e       state;
    div_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sgn_div;
    logic             dvd_neg;
    logic             dvs_neg;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             accept;
    logic             last_step;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .shift_in (quo[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign accept    = (start_i == DIV_START) && !annul_i;
    assign last_step = (cnt == CNT_W'(WIDTH));

    assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;

    // Truncating signed division: quotient sign from the XOR, remainder follows dividend.
    assign quo_fix = (sgn_div && (dvd_neg ^ dvs_neg)) ? ('0 - quo) : quo;
    assign rem_fix = (sgn_div && dvd_neg) ? ('0 - rem) : rem;

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE: begin
                if (accept) state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: state_next = DIV_END;
            DIV_ON: begin
                if (annul_i)        state_next = DIV_FREE;
                else if (last_step) state_next = DIV_END;
            end
            DIV_END: begin
                if (start_i == DIV_STOP) state_next = DIV_FREE;
            end
            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            sgn_div  <= 1'b0;
            dvd_neg  <= 1'b0;
            dvs_neg  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (accept) begin
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= op1_mag;
                        divisor <= op2_mag;
                        sgn_div <= signed_div_i;
                        dvd_neg <= opdata1_i[WIDTH-1];
                        dvs_neg <= opdata2_i[WIDTH-1];
                    end
                end
                DIV_BY_ZERO: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end else if (!last_step) begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal expectations,
// then randomized divisions checked against a plain-arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = 64'h0;
    logic        prev_ready = 1'b0;
    bit          chk_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ma, mb, q, r;
        logic        na, nb;
        if (b == 32'h0) return 64'h0;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (32'h0 - a) : a;
        mb = nb ? (32'h0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = 32'h0 - q;
        if (na) r = 32'h0 - r;
        return {r, q};
    endfunction

    // Result must appear on the rising edge of ready, hold while ready, else be zero.
    always @(negedge clk) begin
        if (chk_en) begin
            if (ready_o && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_ready: ready_o=1 result=%h, expected ready_o=0", result_o);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("result", result_o, cur_exp);
                end
            end else if (ready_o) begin
                check("result_hold", result_o, cur_exp);
            end else begin
                check("idle_zero", result_o, 64'h0);
            end
        end
        prev_ready = ready_o;
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] expv, input int exp_lat, input int hold,
                          input bit scramble);
        int n;
        exp_q.push_back(expv);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
        end while (!ready_o && n < 60);
        check("latency", 64'(n), 64'(exp_lat));
        if (!ready_o) exp_q.delete();
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", 64'(ready_o), 64'h0);
        check("result_clear", result_o, 64'h0);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        logic        s;
        int          k;

        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'h0);
        check("reset_result", result_o, 64'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 3, 1'b0);
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
        do_div(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 34, 0, 1'b0);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, 0, 1'b0);
        do_div(32'd5, 32'd9, 1'b0, 64'h00000005_00000000, 34, 0, 1'b0);
        do_div(32'd123, 32'd0, 1'b1, 64'h0, 2, 5, 1'b0);

        // Annul at cnt=10: edge E11 carries annul.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_div_i = 1'b0;
        start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'h0);
        repeat (40) @(posedge clk);
        #1;
        do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 0, 1'b0);

        // start_i dropped mid-division is ignored; END then exits after one cycle.
        exp_q.push_back(64'h00000002_0000000E);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 1;
        while (!ready_o && n < 60) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("latency_start_low", 64'(n), 64'd34);
        if (!ready_o) exp_q.delete();
        @(posedge clk);
        #1;
        check("end_exit", 64'(ready_o), 64'h0);

        // Reset at cnt=20 with operands changing underneath.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_i = 1'b0;
        check("midrst_ready", 64'(ready_o), 64'h0);
        check("midrst_result", result_o, 64'h0);
        do_div(32'd1000, 32'd33, 1'b0, 64'h0000000A_0000001E, 34, 0, 1'b0);
        do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            k = $urandom_range(0, 7);
            case (k)
                0: b = 32'h0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF;
                3: begin b = $urandom; a = 32'h80000000; end
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, model(a, b, s), (b == 32'h0) ? 2 : 34,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
